// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sram_pkg
//  Description : Shared definitions for the block-RAM port driver: the
//                write-mask width derivation and the default-sized request
//                struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // One mask bit covers MASK_UNIT data bits; a partial last lane still gets a bit.
  function automatic int mask_width(input int data_width, input int mask_unit);
    return (data_width + mask_unit - 1) / mask_unit;
  endfunction

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_MASK_UNIT  = 8;
  localparam int DEF_MASK_WIDTH = mask_width(DEF_DATA_WIDTH, DEF_MASK_UNIT);

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_MASK_WIDTH-1:0] mask;
    logic [DEF_DATA_WIDTH-1:0] data;
  } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_port_driver_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sram_port_if
//  Description : Request stream, response stream and RAM-port signals of one
//                sram_port_driver instance.
//  Modports    : slave  - the driver (accepts requests, drives RAM + responses)
//                master - the surroundings (upstream initiator, consumer, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int MASK_UNIT  = 8
);
  localparam int MASK_WIDTH = sram_pkg::mask_width(DATA_WIDTH, MASK_UNIT);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [MASK_WIDTH-1:0] req_mask;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  logic                  mem_enable;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MASK_WIDTH-1:0] mem_mask;
  logic [DATA_WIDTH-1:0] mem_dataIn;
  logic [DATA_WIDTH-1:0] mem_dataOut;

  modport slave (
    input  req_valid, req_write, req_addr, req_mask, req_data,
    input  resp_ready, mem_dataOut,
    output req_ready, resp_valid, resp_data,
    output mem_enable, mem_write, mem_addr, mem_mask, mem_dataIn
  );

  modport master (
    output req_valid, req_write, req_addr, req_mask, req_data,
    output resp_ready, mem_dataOut,
    input  req_ready, resp_valid, resp_data,
    input  mem_enable, mem_write, mem_addr, mem_mask, mem_dataIn
  );

endinterface
`default_nettype wire

// File: rtl/sram_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sram_resp_fifo
//  Description : Circular response buffer holding read data returned by the
//                RAM until the consumer pops it. Storage is not reset.
//  Ports       : clock, reset (async, active-high)
//                push/push_data - write an entry at the tail
//                pop            - drop the head entry
//                head_data      - current head entry
//                count          - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_resp_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2
) (
  input  wire logic                           clock,
  input  wire logic                           reset,
  input  wire logic                           push,
  input  wire logic [DATA_WIDTH-1:0]          push_data,
  input  wire logic                           pop,
  output logic      [DATA_WIDTH-1:0]          head_data,
  output logic      [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop_eff;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Popping an empty buffer is ignored so a stray pop cannot underflow count.
  assign pop_eff = pop && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push)    tail_d = wrap_inc(tail_q);
    if (pop_eff) head_d = wrap_inc(head_q);
    case ({push, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) store_q[tail_q] <= push_data;
  end

  assign head_data = store_q[head_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/sram_port_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_driver
//  Description : Adapts a valid/ready request stream onto one block-RAM port
//                and returns read data on a valid/ready response stream. The
//                RAM's one-cycle read latency is absorbed by a response FIFO,
//                and read issue is throttled so a returning word always has
//                a free FIFO slot.
//  Ports       : clock, reset (async, active-high)
//                bus (sram_port_if.slave): req_*, resp_*, mem_*
//  Combinational paths: resp_ready -> req_ready -> mem_enable, req_* -> mem_*
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_driver
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int MASK_UNIT  = 8,
  parameter int RESP_DEPTH = 2   // >= 1; 2 sustains one read per cycle
) (
  input wire logic   clock,
  input wire logic   reset,
  sram_port_if.slave bus
);
  localparam int MASK_WIDTH = mask_width(DATA_WIDTH, MASK_UNIT);
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int LVL_W      = CNT_W + 1;

  logic [CNT_W-1:0]      occ;
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic                  accept;
  logic                  rd_room;
  logic [LVL_W-1:0]      level;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [MASK_WIDTH-1:0] mask_out;
  logic [DATA_WIDTH-1:0] head_data;

  assign pop = bus.resp_valid && bus.resp_ready;

  // Slots committed at the coming edge: stored words plus the word the RAM
  // returns from the previous read, less the word leaving this cycle. pop
  // implies occ >= 1, so the subtraction never wraps.
  assign level   = LVL_W'(occ) + LVL_W'(inflight_q) - LVL_W'(pop);
  assign rd_room = level < LVL_W'(RESP_DEPTH);

  assign bus.req_ready = bus.req_write || rd_room;
  assign accept        = bus.req_valid && bus.req_ready;

  assign addr_out = bus.req_addr;
  assign mask_out = bus.req_write ? bus.req_mask : '0;

  assign bus.mem_enable = accept;
  assign bus.mem_write  = bus.req_write;
  assign bus.mem_addr   = addr_out;
  assign bus.mem_mask   = mask_out;
  assign bus.mem_dataIn = bus.req_data;

  // mem_dataOut is valid the cycle after a read edge; capture it then.
  assign inflight_d = accept && !bus.req_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

  sram_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (bus.mem_dataOut),
    .pop       (pop),
    .head_data (head_data),
    .count     (occ)
  );

  assign bus.resp_valid = (occ != '0);
  assign bus.resp_data  = head_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_driver
//  Description : Self-checking bench for sram_port_driver with a behavioural
//                block RAM, a shadow memory and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_driver;
  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int MW    = 16;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_UNIT(8)) bus ();

  sram_port_driver #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MASK_UNIT  (8),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Never-written words read back as a per-address pattern.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- behavioural block RAM ----------------
  logic [DW-1:0] ram [1024];
  logic [1023:0] ram_wr;
  logic [DW-1:0] ram_cur;

  always @(posedge clk) begin
    if (bus.mem_enable === 1'b1) begin
      ram_cur = (ram_wr[bus.mem_addr] === 1'b1) ? ram[bus.mem_addr] : init_val(bus.mem_addr);
      if (bus.mem_write) begin
        ram[bus.mem_addr]    <= merge(ram_cur, bus.mem_dataIn, bus.mem_mask);
        ram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_dataOut <= ram_cur;
      end
    end
  end

  // ---------------- shadow memory, protocol model, scoreboard ----------------
  logic [DW-1:0] sh [1024];
  logic [1023:0] sh_wr;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] sb_exp;
  logic [DW-1:0] sh_cur;
  int            m_occ = 0;
  bit            m_infl = 1'b0;
  bit            m_pop, m_rdy, m_acc;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      sb.delete();
      m_occ  = 0;
      m_infl = 1'b0;
    end else begin
      m_pop = (m_occ != 0) && (bus.resp_ready == 1'b1);
      m_rdy = bus.req_write ? 1'b1 : ((m_occ + int'(m_infl) - int'(m_pop)) < DEPTH);
      m_acc = bus.req_valid && m_rdy;
      chk1("resp_valid", bus.resp_valid, m_occ != 0);
      chk1("req_ready", bus.req_ready, m_rdy);
      chk1("mem_enable", bus.mem_enable, m_acc);
      if (m_acc) begin
        chk("mem_addr", DW'(bus.mem_addr), DW'(bus.req_addr));
        chk1("mem_write", bus.mem_write, bus.req_write);
        chk("mem_mask", DW'(bus.mem_mask), bus.req_write ? DW'(bus.req_mask) : '0);
        if (bus.req_write) chk("mem_dataIn", bus.mem_dataIn, bus.req_data);
      end
      if (m_pop) begin
        chkn("sb_nonempty", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          sb_exp = sb.pop_front();
          chk("resp_data", bus.resp_data, sb_exp);
        end
      end
      if (m_acc) begin
        sh_cur = (sh_wr[bus.req_addr] === 1'b1) ? sh[bus.req_addr] : init_val(bus.req_addr);
        if (bus.req_write) begin
          sh[bus.req_addr]    = merge(sh_cur, bus.req_data, bus.req_mask);
          sh_wr[bus.req_addr] = 1'b1;
        end else begin
          sb.push_back(sh_cur);
        end
      end
      m_occ  = m_occ + int'(m_infl) - int'(m_pop);
      m_infl = m_acc && !bus.req_write;
      chkn("outstanding_le_depth", int'(sb.size() <= DEPTH), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [MW-1:0] m,
                       input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_mask  = m;
    bus.req_data  = d;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_mask  = '0;
    bus.req_data  = '0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chkn(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] WORD = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  int n;

  initial begin
    rst = 1'b1;
    idle();
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_req_ready", bus.req_ready, 1'b1);
    chk1("reset_resp_valid", bus.resp_valid, 1'b0);
    chk1("reset_mem_enable", bus.mem_enable, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Reset while a read is in flight: its data must never surface.
    drive(1'b0, 10'h005, '0, '0);
    step();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("rst_mid_resp_valid", bus.resp_valid, 1'b0);
      chk1("rst_mid_req_ready", bus.req_ready, 1'b1);
    end
    step();

    // Write then read: data appears two cycles after the read is accepted.
    drive(1'b1, 10'h010, '1, WORD);
    step();
    drive(1'b0, 10'h010, '0, '0);
    step();
    idle();
    @(negedge clk);
    chk1("wr_rd_lat1_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    chk1("wr_rd_lat2_valid", bus.resp_valid, 1'b1);
    chk("wr_rd_data", bus.resp_data, WORD);
    step();

    // Masked write touches only byte lane 0.
    drive(1'b1, 10'h3FF, '1, '1);
    step();
    drive(1'b1, 10'h3FF, 16'h0001, '0);
    step();
    drive(1'b0, 10'h3FF, '0, '0);
    step();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk1("masked_valid", bus.resp_valid, 1'b1);
    chk("masked_data", bus.resp_data, {{120{1'b1}}, 8'h00});
    step();

    // Streaming: one read per cycle, responses on consecutive cycles.
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1'b0, AW'(k), '0, '0);
      else       idle();
      @(negedge clk);
      if (k < 8 && bus.req_ready) n++;
      if (k >= 2) chk1("stream_valid", bus.resp_valid, 1'b1);
      step();
    end
    chkn("stream_accepts", n, 8);
    drain("stream_drained");

    // Backpressure: only DEPTH reads outstanding, writes still flow.
    bus.resp_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, AW'(32 + n), '0, '0);
      @(negedge clk);
      if (bus.req_ready) n++;
      step();
    end
    chkn("bp_accepts", n, 2);
    drive(1'b0, 10'h030, '0, '0);
    @(negedge clk);
    chk1("bp_read_blocked", bus.req_ready, 1'b0);
    step();
    drive(1'b1, 10'h040, '1, ~WORD);
    @(negedge clk);
    chk1("bp_write_ready", bus.req_ready, 1'b1);
    chk1("bp_write_enable", bus.mem_enable, 1'b1);
    step();
    idle();
    bus.resp_ready = 1'b1;
    drain("bp_drained");

    // Read stream against a toggling consumer.
    n = 0;
    for (int k = 0; k < 30; k++) begin
      bus.resp_ready = (k % 2 == 0);
      drive(1'b0, AW'(256 + n), '0, '0);
      @(negedge clk);
      if (bus.req_ready) n++;
      step();
    end
    idle();
    bus.resp_ready = 1'b1;
    chkn("toggle_accepts_min", int'(n >= 10), 1);
    drain("toggle_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_port_driver.md
# sram_port_driver

Initiator-side adapter that turns a valid/ready request stream into the single-port enable/write/addr/mask/dataIn protocol of the team's FPGA block RAM, and returns read data on a valid/ready response stream. It absorbs the RAM's fixed one-cycle read latency by holding returned data in a small response FIFO, and it throttles read issue so no read result is ever lost under downstream backpressure. One instance drives one RAM port (rw0 or rw1).

## Interface
- DATA_WIDTH, 128, data bits per word
- ADDR_WIDTH, 10, word address bits
- MASK_UNIT, 8, data bits per write-mask bit
- MASK_WIDTH, ceil(DATA_WIDTH/MASK_UNIT), derived; must not be overridden
- RESP_DEPTH, 2, response FIFO entries; must be >= 1; 2 is required for one read per cycle

- clock  in  1  sole clock; the RAM port clock is tied to this
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_mask  in  MASK_WIDTH  byte-lane enables; writes only
- req_data  in  DATA_WIDTH  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes the data
- resp_data  out  DATA_WIDTH  read data, in request order
- mem_enable  out  1  to RAM enable
- mem_write  out  1  to RAM write
- mem_addr  out  ADDR_WIDTH  to RAM addr
- mem_mask  out  MASK_WIDTH  to RAM mask
- mem_dataIn  out  DATA_WIDTH  to RAM dataIn
- mem_dataOut  in  DATA_WIDTH  from RAM dataOut; valid the cycle after a read edge

## Operation
- Accept = req_valid && req_ready.
- Writes: req_ready = 1 at all times; no response is generated.
- Reads: req_ready = (occ + inflight − pop) < RESP_DEPTH.
  - occ = FIFO occupancy.
  - inflight = read issued at the previous edge.
  - pop = resp_valid && resp_ready.
- mem_enable = accept. mem_write, mem_addr, mem_mask and mem_dataIn pass through the req_* signals combinationally.
  - mem_mask is forced to 0 on reads.
  - mem_* values are don't-care when mem_enable = 0.
- inflight register: set at any edge where a read is accepted, cleared otherwise.
- While inflight = 1, the next edge pushes mem_dataOut into the FIFO. The push is guaranteed to have room by the req_ready rule.
- FIFO: circular buffer with head and tail pointers that wrap modulo RESP_DEPTH.
  - Push and pop in the same cycle leave occ unchanged.
  - resp_data is the head entry.
  - resp_valid = (occ != 0).
  - There is no bypass path from mem_dataOut to resp_data.
- Ordering: responses return strictly in read-issue order.
  - A write accepted in the cycle after a read does not corrupt that read's data, because the RAM holds dataOut until its next read.
- Reset (asynchronous, may occur mid-operation):
  - inflight, occ and both pointers go to 0.
  - Any read in flight is discarded.
  - FIFO storage is not reset.

## Timing
- Reset values: req_ready = 1, resp_valid = 0, mem_enable = 0. resp_data is X, since storage is not reset.
- Read latency: read accepted at edge E0 → RAM samples at E0 → FIFO push at E1 → resp_valid high in the cycle after E1. Minimum latency is 2 cycles.
- Throughput: with RESP_DEPTH = 2 and resp_ready held high, one read is accepted every cycle.
- Backpressure: with resp_ready low, at most RESP_DEPTH reads are outstanding (FIFO plus inflight). After that, req_ready for reads stays low until a pop occurs.
- Combinational paths:
  - resp_ready → req_ready → mem_enable.
  - req_* → mem_*.
  - Both are documented; the integrator registers upstream if timing requires.
- Response handshake: resp_valid and resp_data stay stable until popped.

## Structure
- Package sram_pkg:
  - the MASK_WIDTH derivation function;
  - a typedef for the request struct (write, addr, mask, data), parameterized through localparams of the default sizes.
- Sub-module sram_resp_fifo:
  - parameters DATA_WIDTH and DEPTH;
  - ports push, push_data, pop, head_data, count;
  - reset is asynchronous, active-high.
- All logic outside the FIFO lives in sram_port_driver: the inflight register and the ready computation.

## Test plan
- Reset mid-read: accept a read to addr 0x005, assert reset at the next edge → resp_valid stays 0 after reset releases, and req_ready = 1.
- Write then read: write 0xDEAD_BEEF… with mask all-ones to addr 0x010, then read 0x010 → resp_data equals the written word 2 cycles after the read is accepted.
- Masked write: write all-ones, then write 0x00 with mask 0x0001 to addr 0x3FF, then read → only byte 0 is zero.
- Streaming: 8 back-to-back reads of addr 0..7 with resp_ready = 1 → 8 accepts in 8 cycles; responses arrive in order on consecutive cycles.
- Backpressure: resp_ready = 0 while issuing reads → exactly 2 accepted, then req_ready = 0 for reads while writes are still accepted. Raising resp_ready drains in order with no loss or duplication.
- Simultaneous push/pop: steady read stream with resp_ready toggling 1010… → occ never exceeds 2 and every response matches its address.
